// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM port-B arbiter family.
// Owner-state encoding and the read-return tag are reused by every variant.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } owner_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester handshakes and the RAM port-B pins.
// The slave modport is the arbiter's view; master is the requesters plus the RAM.
interface ram_port_arbiter_if import ram_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              REQ0, REQ1;
  logic              WE0, WE1;
  logic [ADDR_W-1:0] ADDR0, ADDR1;
  logic [DATA_W-1:0] WDATA0, WDATA1;
  logic              GNT0, GNT1;
  logic              RVALID0, RVALID1;
  logic [DATA_W-1:0] RDATA0, RDATA1;
  logic              ENB;
  logic              WEB;
  logic [ADDR_W-1:0] ADDRB;
  logic [DATA_W-1:0] DINB;
  logic [DATA_W-1:0] DOUTB;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, DOUTB,
    output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, ENB, WEB, ADDRB, DINB
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, DOUTB,
    input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, ENB, WEB, ADDRB, DINB
  );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner selection for two requesters: round-robin with a
// bounded contended burst, or fixed priority to requester 0.
module ram_arb_pick import ram_arb_pkg::*; #(
  parameter int MAX_BURST = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic             req0,
  input  logic             req1,
  input  owner_e           owner,
  input  logic [CNT_W-1:0] cnt,
  output logic [1:0]       gnt
);

  logic burst_done;

  assign burst_done = (cnt >= CNT_W'(MAX_BURST));

  always_comb begin
    gnt = 2'b00;
    if (PRIO_MODE != 0) begin
      gnt = {req1 & ~req0, req0};
    end else begin
      case (owner)
        OWN0: begin
          if (req0 && !(req1 && burst_done)) gnt = 2'b01;
          else if (req1)                     gnt = 2'b10;
        end
        OWN1: begin
          if (req1 && !(req0 && burst_done)) gnt = 2'b10;
          else if (req0)                     gnt = 2'b01;
        end
        default: begin
          if (req0)      gnt = 2'b01;
          else if (req1) gnt = 2'b10;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port B between two requesters: owner FSM, registered ENB and a
// two-stage read-tag pipeline that returns data two cycles after the grant.
module ram_port_arbiter import ram_arb_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4,
  parameter int PRIO_MODE = 0
) (
  input logic               CLK,
  input logic               RSTn,
  ram_port_arbiter_if.slave bus
);

  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              enb_q, enb_d;
  rd_tag_t           tag_p1_q, tag_p1_d;
  rd_tag_t           tag_p2_q, tag_p2_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        pick_gnt, gnt;
  logic              web;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dinb;

  ram_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .PRIO_MODE (PRIO_MODE)
  ) u_pick (
    .req0  (bus.REQ0),
    .req1  (bus.REQ1),
    .owner (owner_q),
    .cnt   (cnt_q),
    .gnt   (pick_gnt)
  );

  // Grants are suppressed while ENB is low so nothing is issued to a disabled RAM.
  assign gnt = pick_gnt & {2{enb_q}};

  // Stage p0: grant cycle, port B driven combinationally from the winner.
  always_comb begin
    web   = 1'b0;
    addrb = '0;
    dinb  = '0;
    if (gnt[0]) begin
      web   = bus.WE0;
      addrb = bus.ADDR0;
      dinb  = bus.WDATA0;
    end else if (gnt[1]) begin
      web   = bus.WE1;
      addrb = bus.ADDR1;
      dinb  = bus.WDATA1;
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    enb_d   = 1'b1;
    if (enb_q) begin
      if (gnt[0]) begin
        if (owner_q == OWN0) begin
          if (bus.REQ1 && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          owner_d = OWN0;
          cnt_d   = {{(CNT_W-1){1'b0}}, bus.REQ1};
        end
      end else if (gnt[1]) begin
        if (owner_q == OWN1) begin
          if (bus.REQ0 && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          owner_d = OWN1;
          cnt_d   = {{(CNT_W-1){1'b0}}, bus.REQ0};
        end
      end else begin
        owner_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Stage p1: RAM has the address, DOUTB valid. Stage p2: data registered out.
  always_comb begin
    tag_p1_d.valid = |(gnt & ~{bus.WE1, bus.WE0});
    tag_p1_d.id    = gnt[1];
    tag_p2_d       = tag_p1_q;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    if (tag_p1_q.valid && !tag_p1_q.id) rdata0_d = bus.DOUTB;
    if (tag_p1_q.valid &&  tag_p1_q.id) rdata1_d = bus.DOUTB;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      owner_q  <= IDLE;
      cnt_q    <= '0;
      enb_q    <= 1'b0;
      tag_p1_q <= '0;
      tag_p2_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      enb_q    <= enb_d;
      tag_p1_q <= tag_p1_d;
      tag_p2_q <= tag_p2_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.GNT0    = gnt[0];
  assign bus.GNT1    = gnt[1];
  assign bus.WEB     = web;
  assign bus.ADDRB   = addrb;
  assign bus.DINB    = dinb;
  assign bus.ENB     = enb_q;
  assign bus.RVALID0 = tag_p2_q.valid & ~tag_p2_q.id;
  assign bus.RVALID1 = tag_p2_q.valid &  tag_p2_q.id;
  assign bus.RDATA0  = rdata0_q;
  assign bus.RDATA1  = rdata1_q;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares port B (read/write, 2048x8) of the dual-port RAM unit between two requesters, e.g. CPU (req 0) and DMA (req 1).
- Provides per-requester request/grant handshake, round-robin arbitration with a bounded burst, and a read-return pipeline matched to the RAM's registered-input timing.
- Port A is outside this block and is driven directly by its own writer.

Parameters:
- ADDR_W, 11, address width; must match RAM depth (2048).
- DATA_W, 8, data width.
- MAX_BURST, 4, max consecutive contended grants to one owner before a forced switch; legal range 1..15.
- PRIO_MODE, 0, 0 = round-robin with burst; 1 = fixed priority, requester 0 always wins and MAX_BURST is ignored.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  synchronous active-low reset.
- REQ0 / REQ1  in  1  access request; held with WE/ADDR/WDATA stable until granted.
- WE0 / WE1  in  1  1 = write, 0 = read.
- ADDR0 / ADDR1  in  ADDR_W  access address.
- WDATA0 / WDATA1  in  DATA_W  write data.
- GNT0 / GNT1  out  1  combinational grant; transfer completes in the cycle where REQn & GNTn.
- RVALID0 / RVALID1  out  1  one-cycle read-data strobe.
- RDATA0 / RDATA1  out  DATA_W  registered read data; held until the next RVALID for that requester.
- ENB  out  1  RAM port B enable (registered).
- WEB  out  1  RAM port B write enable.
- ADDRB  out  ADDR_W  RAM port B address.
- DINB  out  DATA_W  RAM port B write data.
- DOUTB  in  DATA_W  RAM port B read data; valid the cycle after the address is presented.

Behaviour:
- Reset values: GNT*=0, RVALID*=0, RDATA*=0, ENB=0, WEB=0, ADDRB=0, DINB=0, owner=IDLE, cnt=0, read pipeline cleared.
- ENB is registered. It is 0 in the cycle after reset is sampled low and 1 in every cycle after reset is released. ENB must stay high the cycle after a write issue, because the RAM gates its registered write enable with the live ENB.
- At most one grant per cycle, and GNTn only when REQn=1.
- Granted cycle: ADDRB/WEB/DINB = the winner's ADDR/WE/WDATA.
- No grant: WEB=0, ADDRB=0, DINB=0.
- Owner FSM states: IDLE, OWN0, OWN1.
  - IDLE: single requester wins. If both request, req 0 wins. Go to OWNn with cnt=1 if the other REQ was high, else cnt=0.
  - OWNn, only n requesting: grant n; cnt unchanged.
  - OWNn, both requesting, cnt<MAX_BURST: grant n; cnt+1.
  - OWNn, both requesting, cnt==MAX_BURST: grant m (the other requester); go to OWNm; cnt=1.
  - OWNn, only m requesting: grant m; go to OWNm; cnt=0.
  - Neither requesting: go to IDLE, cnt=0.
- PRIO_MODE=1: GNT0=REQ0; GNT1=REQ1&~REQ0; FSM state is irrelevant.
- Write: no response. The RAM performs the write at the end of grant cycle t+1.
- Read latency: grant in cycle t → DOUTB valid in t+1 → captured into RDATAn at edge t+2 → RVALIDn=1 during t+2 only.
- Two-stage tag pipeline (valid, id) supports back-to-back reads from either requester at 1 read/cycle.
- Read-after-write to the same address in consecutive grants returns the new data; no hazard logic is required.
- Port A/B same-address write collision: port B data wins. This is documented only; the arbiter does not check for it.
- Reset mid-operation: in-flight reads never raise RVALID. A write granted in the cycle immediately before reset is sampled is dropped, because ENB=0.

Decomposition:
- ram_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - Owner state encoding: IDLE=2'b00, OWN0=2'b01, OWN1=2'b10.
  - Read-tag struct {valid, id}.
- One sub-module: ram_arb_pick, combinational winner selection (inputs: REQ0, REQ1, owner, cnt, PRIO_MODE; output: grant vector). It is reused by future multi-port variants.
- FSM, cnt, ENB register and read pipeline stay in the top module.

Test Plan:
- Reset then idle → ENB goes 0→1 the cycle after RSTn rises. GNT*/RVALID*/WEB stay 0 and ADDRB=0.
- REQ0 write 0x7FF←0xA5, then REQ0 read 0x7FF on the next cycle → GNT0 both cycles. RVALID0 2 cycles after the read grant with RDATA0=0xA5.
- REQ0 and REQ1 both held high for reads, MAX_BURST=4 → grant pattern 0,0,0,0,1,1,1,1,0,…; RVALIDs follow 2 cycles later with correct per-requester data.
- Only REQ1 for 10 cycles, then REQ0 joins → immediate switch rules per FSM. Verify REQ1 is never starved for more than MAX_BURST cycles.
- PRIO_MODE=1, both REQ high for 6 cycles → GNT0 every cycle and GNT1 never; GNT1 follows on the first cycle REQ0 drops.
- Read granted at cycle t, RSTn low at edge t+1 → no RVALID; RDATA*=0. Write granted one cycle before reset → memory location unchanged on readback.
